// File: rtl/mem_arbiter_if.sv
// Bundles the IF and data requester ports, the external memory port, and the stall/error status.
// The arbiter connects through the slave modport. The environment driving it connects through the master modport.
interface mem_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_ack_o;

  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [31:0] dm_rdata_o;
  logic        dm_ack_o;

  logic        mem_enable_o;
  logic        mem_write_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;
  logic        mem_ack_i;

  logic        stall_o;
  logic        err_o;

  modport slave (
    input  if_req_i, if_addr_i,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  mem_data_i, mem_ack_i,
    output if_data_o, if_ack_o,
    output dm_rdata_o, dm_ack_o,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    output stall_o, err_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output mem_data_i, mem_ack_i,
    input  if_data_o, if_ack_o,
    input  dm_rdata_o, dm_ack_o,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    input  stall_o, err_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one multi-cycle memory port between instruction fetch and data access.
// Data accesses win ties, IF gets a starvation guard, and a watchdog aborts accesses to a hung memory.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input logic          clk_i,
    input logic          rst_i,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] TMO_MAX    = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        mem_enable_q, mem_enable_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        if_ack_q, if_ack_d;
    logic        dm_ack_q, dm_ack_d;
    logic        err_q, err_d;

    logic        if_elig, dm_elig, grant_d, grant_i, owner_d;
    logic [7:0]  tmo_inc;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            streak_q     <= '0;
            tmo_q        <= '0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            if_data_q    <= '0;
            dm_rdata_q   <= '0;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            tmo_q        <= tmo_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            if_data_q    <= if_data_d;
            dm_rdata_q   <= dm_rdata_d;
            if_ack_q     <= if_ack_d;
            dm_ack_q     <= dm_ack_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        streak_d     = streak_q;
        tmo_d        = tmo_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        if_data_d    = if_data_q;
        dm_rdata_d   = dm_rdata_q;
        if_ack_d     = 1'b0;
        dm_ack_d     = 1'b0;
        err_d        = err_q;
        owner_d      = (state_q == BUSY_D);
        tmo_inc      = tmo_q + 8'd1;

        // A requester in its ack cycle is still showing the request it just had served
        if_elig = bus.if_req_i & ~if_ack_q;
        dm_elig = bus.dm_req_i & ~dm_ack_q;
        grant_d = dm_elig & ~(if_elig & (streak_q == STREAK_MAX));
        grant_i = if_elig & ~grant_d;

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d      = BUSY_D;
                    mem_enable_d = 1'b1;
                    mem_write_d  = bus.dm_we_i;
                    mem_addr_d   = bus.dm_addr_i;
                    mem_data_d   = bus.dm_we_i ? bus.dm_wdata_i : '0;
                    tmo_d        = '0;
                    if (bus.if_req_i)
                        streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;
                    else
                        streak_d = '0;
                end else if (grant_i) begin
                    state_d      = BUSY_I;
                    mem_enable_d = 1'b1;
                    mem_write_d  = 1'b0;
                    mem_addr_d   = bus.if_addr_i;
                    mem_data_d   = '0;
                    tmo_d        = '0;
                    streak_d     = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                // A memory ack in the same cycle the watchdog expires completes the access normally
                if (bus.mem_ack_i) begin
                    state_d      = IDLE;
                    mem_enable_d = 1'b0;
                    mem_write_d  = 1'b0;
                    if (owner_d) begin
                        dm_rdata_d = bus.mem_data_i;
                        dm_ack_d   = 1'b1;
                    end else begin
                        if_data_d  = bus.mem_data_i;
                        if_ack_d   = 1'b1;
                    end
                end else if (tmo_inc == TMO_MAX) begin
                    state_d      = IDLE;
                    mem_enable_d = 1'b0;
                    mem_write_d  = 1'b0;
                    err_d        = 1'b1;
                    tmo_d        = tmo_inc;
                    if (owner_d) begin
                        dm_rdata_d = '0;
                        dm_ack_d   = 1'b1;
                    end else begin
                        if_data_d  = '0;
                        if_ack_d   = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_enable_o = mem_enable_q;
    assign bus.mem_write_o  = mem_write_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_data_o   = mem_data_q;
    assign bus.if_data_o    = if_data_q;
    assign bus.if_ack_o     = if_ack_q;
    assign bus.dm_rdata_o   = dm_rdata_q;
    assign bus.dm_ack_o     = dm_ack_q;
    assign bus.err_o        = err_q;
    assign bus.stall_o      = (bus.if_req_i & ~if_ack_q) | (bus.dm_req_i & ~dm_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. It drives requests and memory acks cycle by cycle and checks against hand-computed values.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge. Outputs are sampled on the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        #4;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.if_req_i   = 1'b0;
        bus.if_addr_i  = '0;
        bus.dm_req_i   = 1'b0;
        bus.dm_we_i    = 1'b0;
        bus.dm_addr_i  = '0;
        bus.dm_wdata_i = '0;
        bus.mem_data_i = '0;
        bus.mem_ack_i  = 1'b0;
        rst_n          = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_en",    32'(bus.mem_enable_o), 32'd0);
        chk("rst_we",    32'(bus.mem_write_o),  32'd0);
        chk("rst_addr",  bus.mem_addr_o,        32'd0);
        chk("rst_ifack", 32'(bus.if_ack_o),     32'd0);
        chk("rst_dmack", 32'(bus.dm_ack_o),     32'd0);
        chk("rst_err",   32'(bus.err_o),        32'd0);
        chk("rst_stall", 32'(bus.stall_o),      32'd0);
        chk("rst_ifdat", bus.if_data_o,         32'd0);
        rst_n = 1'b1;

        // Lone IF read with a memory ack in cycle 3
        cyc(); bus.if_req_i = 1'b1; bus.if_addr_i = 32'h10; sample();
        chk("t1_stall0", 32'(bus.stall_o), 32'd1);
        chk("t1_en0",    32'(bus.mem_enable_o), 32'd0);
        cyc(); sample();
        chk("t1_en1",    32'(bus.mem_enable_o), 32'd1);
        chk("t1_addr1",  bus.mem_addr_o, 32'h10);
        chk("t1_we1",    32'(bus.mem_write_o), 32'd0);
        chk("t1_stall1", 32'(bus.stall_o), 32'd1);
        cyc(); sample();
        chk("t1_en2",    32'(bus.mem_enable_o), 32'd1);
        cyc(); bus.mem_ack_i = 1'b1; bus.mem_data_i = 32'h1234_5678; sample();
        chk("t1_en3",    32'(bus.mem_enable_o), 32'd1);
        chk("t1_ack3",   32'(bus.if_ack_o), 32'd0);
        chk("t1_stall3", 32'(bus.stall_o), 32'd1);
        cyc(); bus.mem_ack_i = 1'b0; bus.mem_data_i = '0; sample();
        chk("t1_ack4",   32'(bus.if_ack_o), 32'd1);
        chk("t1_data4",  bus.if_data_o, 32'h1234_5678);
        chk("t1_stall4", 32'(bus.stall_o), 32'd0);
        chk("t1_en4",    32'(bus.mem_enable_o), 32'd0);
        cyc(); bus.if_req_i = 1'b0; sample();
        chk("t1_ack5",   32'(bus.if_ack_o), 32'd0);
        chk("t1_en5",    32'(bus.mem_enable_o), 32'd0);
        chk("t1_hold5",  bus.if_data_o, 32'h1234_5678);

        // Simultaneous requests: the data side goes first
        cyc();
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h20;
        bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_addr_i = 32'h100;
        sample();
        chk("t2_stall0", 32'(bus.stall_o), 32'd1);
        cyc(); bus.mem_ack_i = 1'b1; bus.mem_data_i = 32'hAAAA_0001; sample();
        chk("t2_en1",    32'(bus.mem_enable_o), 32'd1);
        chk("t2_addr1",  bus.mem_addr_o, 32'h100);
        cyc(); bus.mem_ack_i = 1'b0; sample();
        chk("t2_dack2",  32'(bus.dm_ack_o), 32'd1);
        chk("t2_ddat2",  bus.dm_rdata_o, 32'hAAAA_0001);
        chk("t2_en2",    32'(bus.mem_enable_o), 32'd0);
        chk("t2_stall2", 32'(bus.stall_o), 32'd1);
        cyc(); bus.dm_req_i = 1'b0; bus.mem_ack_i = 1'b1; bus.mem_data_i = 32'hBBBB_0002; sample();
        chk("t2_en3",    32'(bus.mem_enable_o), 32'd1);
        chk("t2_addr3",  bus.mem_addr_o, 32'h20);
        chk("t2_dack3",  32'(bus.dm_ack_o), 32'd0);
        cyc(); bus.mem_ack_i = 1'b0; sample();
        chk("t2_iack4",  32'(bus.if_ack_o), 32'd1);
        chk("t2_idat4",  bus.if_data_o, 32'hBBBB_0002);
        chk("t2_dhold4", bus.dm_rdata_o, 32'hAAAA_0001);
        cyc(); bus.if_req_i = 1'b0; sample();
        chk("t2_en5",    32'(bus.mem_enable_o), 32'd0);

        // Data write
        cyc();
        bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b1; bus.dm_addr_i = 32'h40; bus.dm_wdata_i = 32'hDEAD_BEEF;
        sample();
        cyc(); sample();
        chk("t3_en1",    32'(bus.mem_enable_o), 32'd1);
        chk("t3_we1",    32'(bus.mem_write_o), 32'd1);
        chk("t3_dat1",   bus.mem_data_o, 32'hDEAD_BEEF);
        chk("t3_addr1",  bus.mem_addr_o, 32'h40);
        cyc(); bus.mem_ack_i = 1'b1; bus.mem_data_i = '0; sample();
        chk("t3_we2",    32'(bus.mem_write_o), 32'd1);
        chk("t3_dat2",   bus.mem_data_o, 32'hDEAD_BEEF);
        chk("t3_ack2",   32'(bus.dm_ack_o), 32'd0);
        cyc(); bus.mem_ack_i = 1'b0; sample();
        chk("t3_ack3",   32'(bus.dm_ack_o), 32'd1);
        chk("t3_we3",    32'(bus.mem_write_o), 32'd0);
        chk("t3_en3",    32'(bus.mem_enable_o), 32'd0);
        cyc(); bus.dm_req_i = 1'b0; bus.dm_we_i = 1'b0; sample();
        chk("t3_ack4",   32'(bus.dm_ack_o), 32'd0);

        // Starvation guard: four data grants while IF is requesting, then IF is forced through
        for (int k = 0; k < 4; k++) begin
            cyc();
            bus.dm_req_i = 1'b1; bus.dm_addr_i = 32'h200 + 32'(k);
            bus.if_req_i = 1'b1; bus.if_addr_i = 32'h300;
            sample();
            chk("t4_idle",  32'(bus.mem_enable_o), 32'd0);
            cyc(); bus.if_req_i = 1'b0; bus.mem_ack_i = 1'b1; bus.mem_data_i = 32'h40 + 32'(k); sample();
            chk("t4_en",    32'(bus.mem_enable_o), 32'd1);
            chk("t4_daddr", bus.mem_addr_o, 32'h200 + 32'(k));
            cyc(); bus.mem_ack_i = 1'b0; sample();
            chk("t4_dack",  32'(bus.dm_ack_o), 32'd1);
            chk("t4_ddat",  bus.dm_rdata_o, 32'h40 + 32'(k));
        end
        cyc(); bus.dm_addr_i = 32'h2FF; bus.if_req_i = 1'b1; sample();
        chk("t4_idle5",  32'(bus.mem_enable_o), 32'd0);
        cyc(); bus.mem_ack_i = 1'b1; bus.mem_data_i = 32'h55; sample();
        chk("t4_iaddr",  bus.mem_addr_o, 32'h300);
        chk("t4_ien",    32'(bus.mem_enable_o), 32'd1);
        chk("t4_iwe",    32'(bus.mem_write_o), 32'd0);
        cyc(); bus.mem_ack_i = 1'b0; sample();
        chk("t4_iack",   32'(bus.if_ack_o), 32'd1);
        chk("t4_idat",   bus.if_data_o, 32'h55);
        cyc(); bus.if_req_i = 1'b0; bus.mem_ack_i = 1'b1; bus.mem_data_i = 32'h66; sample();
        chk("t4_raddr",  bus.mem_addr_o, 32'h2FF);
        chk("t4_ren",    32'(bus.mem_enable_o), 32'd1);
        cyc(); bus.mem_ack_i = 1'b0; sample();
        chk("t4_rack",   32'(bus.dm_ack_o), 32'd1);
        chk("t4_rdat",   bus.dm_rdata_o, 32'h66);
        cyc(); bus.dm_req_i = 1'b0; sample();
        chk("t4_end",    32'(bus.mem_enable_o), 32'd0);

        // A memory ack in the eighth busy cycle wins over the watchdog
        cyc(); bus.dm_req_i = 1'b1; bus.dm_addr_i = 32'h500; sample();
        for (int c = 1; c <= 7; c++) begin
            cyc(); sample();
            chk("t5a_en", 32'(bus.mem_enable_o), 32'd1);
        end
        cyc(); bus.mem_ack_i = 1'b1; bus.mem_data_i = 32'hCAFE_0008; sample();
        chk("t5a_en8",   32'(bus.mem_enable_o), 32'd1);
        cyc(); bus.mem_ack_i = 1'b0; sample();
        chk("t5a_ack",   32'(bus.dm_ack_o), 32'd1);
        chk("t5a_dat",   bus.dm_rdata_o, 32'hCAFE_0008);
        chk("t5a_err",   32'(bus.err_o), 32'd0);
        cyc(); bus.dm_req_i = 1'b0; sample();
        chk("t5a_err2",  32'(bus.err_o), 32'd0);

        // Timeout: no memory ack at all
        cyc(); bus.dm_req_i = 1'b1; bus.dm_addr_i = 32'h504; sample();
        for (int c = 1; c <= 8; c++) begin
            cyc(); sample();
            chk("t5b_en", 32'(bus.mem_enable_o), 32'd1);
        end
        cyc(); sample();
        chk("t5b_en9",   32'(bus.mem_enable_o), 32'd0);
        chk("t5b_ack",   32'(bus.dm_ack_o), 32'd1);
        chk("t5b_dat",   bus.dm_rdata_o, 32'd0);
        chk("t5b_err",   32'(bus.err_o), 32'd1);
        cyc(); bus.dm_req_i = 1'b0; sample();
        chk("t5b_ack2",  32'(bus.dm_ack_o), 32'd0);
        chk("t5b_err2",  32'(bus.err_o), 32'd1);
        cyc(); bus.if_req_i = 1'b1; bus.if_addr_i = 32'h600; sample();
        cyc(); bus.mem_ack_i = 1'b1; bus.mem_data_i = 32'h77; sample();
        chk("t5b_ien",   32'(bus.mem_enable_o), 32'd1);
        cyc(); bus.mem_ack_i = 1'b0; sample();
        chk("t5b_iack",  32'(bus.if_ack_o), 32'd1);
        chk("t5b_idat",  bus.if_data_o, 32'h77);
        chk("t5b_err3",  32'(bus.err_o), 32'd1);
        cyc(); bus.if_req_i = 1'b0; sample();

        // A stray memory ack while idle has no effect
        cyc(); bus.mem_ack_i = 1'b1; bus.mem_data_i = 32'h99; sample();
        chk("idle_en",   32'(bus.mem_enable_o), 32'd0);
        cyc(); bus.mem_ack_i = 1'b0; sample();
        chk("idle_iack", 32'(bus.if_ack_o), 32'd0);
        chk("idle_dack", 32'(bus.dm_ack_o), 32'd0);
        chk("idle_idat", bus.if_data_o, 32'h77);

        // Asynchronous reset in the middle of an IF access
        cyc(); bus.if_req_i = 1'b1; bus.if_addr_i = 32'h700; sample();
        cyc(); sample();
        chk("t6_en1",    32'(bus.mem_enable_o), 32'd1);
        chk("t6_addr1",  bus.mem_addr_o, 32'h700);
        cyc(); #1; rst_n = 1'b0; bus.if_req_i = 1'b0; #1;
        chk("t6_rst_en",    32'(bus.mem_enable_o), 32'd0);
        chk("t6_rst_ack",   32'(bus.if_ack_o), 32'd0);
        chk("t6_rst_err",   32'(bus.err_o), 32'd0);
        chk("t6_rst_stall", 32'(bus.stall_o), 32'd0);
        chk("t6_rst_addr",  bus.mem_addr_o, 32'd0);
        chk("t6_rst_idat",  bus.if_data_o, 32'd0);
        cyc(); cyc(); rst_n = 1'b1; sample();
        chk("t6_rel_en", 32'(bus.mem_enable_o), 32'd0);
        cyc(); bus.if_req_i = 1'b1; bus.if_addr_i = 32'h800; sample();
        cyc(); bus.mem_ack_i = 1'b1; bus.mem_data_i = 32'h88; sample();
        chk("t6_en",     32'(bus.mem_enable_o), 32'd1);
        chk("t6_addr",   bus.mem_addr_o, 32'h800);
        cyc(); bus.mem_ack_i = 1'b0; sample();
        chk("t6_ack",    32'(bus.if_ack_o), 32'd1);
        chk("t6_dat",    bus.if_data_o, 32'h88);
        chk("t6_err",    32'(bus.err_o), 32'd0);
        cyc(); bus.if_req_i = 1'b0; sample();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
